// File: rtl/booth_mul_sched_if.sv
// Bus bundle between the scheduler, its requesters, the shared multiplier core
// and the response consumer. The scheduler uses the slave modport.
interface booth_mul_sched_if #(
    parameter int WIDTH = 571,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;

    logic                  mul_start;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic                  mul_done;
    logic [2*WIDTH-1:0]    mul_c;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_c;
    logic                  rsp_err;

    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_done, mul_c, rsp_ready,
        output req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_c, rsp_err, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_done, mul_c, rsp_ready,
        input  req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_c, rsp_err, busy
    );
endinterface

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one sequential multiplier core among NREQ
// requesters, with a watchdog on the core and a tagged valid/ready response.
module booth_mul_sched #(
    parameter int WIDTH  = 571,
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int MAXLAT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    booth_mul_sched_if.slave    bus,
    output logic [1:0]          o_dbg_state
);
    // Handshakes: a request transfers on the edge where req_valid[i] and
    // req_ready[i] are both high; a response transfers on the edge where
    // rsp_valid and rsp_ready are both high. Payloads are stable while waiting.

    localparam int CW = $clog2(MAXLAT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [IDW-1:0]       r_last;
    logic [CW-1:0]        r_wdog;
    logic [WIDTH-1:0]     r_mul_a;
    logic [WIDTH-1:0]     r_mul_b;
    logic                 r_rsp_valid;
    logic [IDW-1:0]       r_rsp_id;
    logic [2*WIDTH-1:0]   r_rsp_c;
    logic                 r_rsp_err;

    logic                 w_grant_any;
    logic [IDW-1:0]       w_grant_id;
    logic [IDW-1:0]       w_idx;
    logic                 w_timeout;
    logic [NREQ-1:0]      w_req_ready;
    logic                 w_mul_start;
    logic                 w_busy;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((int'(r_last) + k) % NREQ);
            if (!w_grant_any && bus.req_valid[w_idx]) begin
                w_grant_any = 1'b1;
                w_grant_id  = w_idx;
            end
        end
    end

    // Timeout fires in the MAXLAT-th RUN cycle.
    assign w_timeout = (r_wdog == CW'(MAXLAT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_grant_any) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_RUN;
            S_RUN:    if (bus.mul_done || w_timeout) w_next = S_HOLD;
            S_HOLD:   if (r_rsp_valid && bus.rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = '0;
        w_mul_start = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_grant_any) w_req_ready = NREQ'(1) << w_grant_id;
            end
            S_LAUNCH: w_mul_start = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last      <= IDW'(NREQ - 1);
            r_wdog      <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_c     <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_mul_a  <= bus.req_a[w_grant_id*WIDTH +: WIDTH];
                        r_mul_b  <= bus.req_b[w_grant_id*WIDTH +: WIDTH];
                        r_rsp_id <= w_grant_id;
                        r_last   <= w_grant_id;
                    end
                end
                S_LAUNCH: r_wdog <= '0;
                S_RUN: begin
                    r_wdog <= r_wdog + CW'(1);
                    // A done in the timeout cycle still delivers the real product.
                    if (bus.mul_done) begin
                        r_rsp_c     <= bus.mul_c;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_rsp_c     <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.mul_start = w_mul_start;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_c     = r_rsp_c;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = w_busy;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed bench for booth_mul_sched with a behavioural multiplier core of
// programmable latency, a hang mode and a spurious-done injector.
module tb_booth_mul_sched;
  localparam int WIDTH  = 571;
  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int MAXLAT = 1023;
  localparam int PW     = 2 * WIDTH;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  booth_mul_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  booth_mul_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .MAXLAT(MAXLAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Core model: done pulses L cycles after the start cycle.
  int core_lat  = 572;
  bit core_hang = 1'b0;
  bit spur_req  = 1'b0;
  int core_cnt  = 0;
  logic [PW-1:0] core_pa, core_pb;

  initial begin
    bus.mul_done = 1'b0;
    bus.mul_c    = '0;
  end

  always @(negedge clk) begin
    bus.mul_done = 1'b0;
    if (spur_req) bus.mul_done = 1'b1;
    if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0 && !core_hang) begin
        core_pa      = PW'(bus.mul_a);
        core_pb      = PW'(bus.mul_b);
        bus.mul_c    = core_pa * core_pb;
        bus.mul_done = 1'b1;
      end
    end
    if (bus.mul_start) core_cnt = core_lat;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_op(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_a[r*WIDTH +: WIDTH] = a;
    bus.req_b[r*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.mul_start, bus.rsp_valid, bus.rsp_err, bus.busy, bus.rsp_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rr=%b st=%b rv=%b re=%b busy=%b id=%0d expected all 0",
               bus.req_ready, bus.mul_start, bus.rsp_valid, bus.rsp_err, bus.busy, bus.rsp_id);
    end
    n_checks++;
    if (bus.mul_a !== '0 || bus.mul_b !== '0 || bus.rsp_c !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got a=%0h b=%0h c=%0h expected 0", bus.mul_a, bus.mul_b, bus.rsp_c);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    do_reset();
    tick();
    n_checks++;
    if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: got rr=%b busy=%b expected 0000/0", bus.req_ready, bus.busy);
    end
  endtask

  task automatic test_single();
    int n;
    core_lat = 572;
    set_op(0, WIDTH'(3), WIDTH'(5));
    bus.req_valid = 4'b0001;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready: got %b expected 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    n_checks++;
    if (bus.mul_start !== 1'b1 || dbg_state !== 2'd1 || bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_start: got st=%b state=%0d rr=%b expected 1/1/0000",
               bus.mul_start, dbg_state, bus.req_ready);
    end
    tick();
    n_checks++;
    if (bus.mul_start !== 1'b0 || dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL single_start_pulse: got st=%b state=%0d expected 0/2", bus.mul_start, dbg_state);
    end
    wait_rsp(n);
    n_checks++;
    if (n + 2 != 574) begin
      n_fail++;
      $display("FAIL single_latency: got %0d expected 574", n + 2);
    end
    n_checks++;
    if (bus.rsp_c !== PW'(15) || bus.rsp_id !== 2'd0 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp: got c=%0h id=%0d err=%b expected f/0/0", bus.rsp_c, bus.rsp_id, bus.rsp_err);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: got rv=%b busy=%b expected 0/0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int exp;
    logic [NREQ-1:0] exp_oh;
    logic [PW-1:0]   exp_c;
    do_reset();
    core_lat = 20;
    for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(i + 2), WIDTH'(i + 100));
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      exp    = g % NREQ;
      exp_oh = 4'b0001 << exp;
      exp_c  = PW'((exp + 2) * (exp + 100));
      n_checks++;
      if (bus.req_ready !== exp_oh) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b expected %b", g, bus.req_ready, exp_oh);
      end
      tick();
      wait_rsp(n);
      n_checks++;
      if (n >= 3000 || bus.rsp_id !== IDW'(exp) || bus.rsp_c !== exp_c) begin
        n_fail++;
        $display("FAIL rr_rsp%0d: got id=%0d c=%0h wait=%0d expected id=%0d c=%0h",
                 g, bus.rsp_id, bus.rsp_c, n, exp, exp_c);
      end
      if (g == 4) bus.req_valid = 4'b0000;
      tick();
    end
    bus.rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    logic [WIDTH-1:0] big;
    logic [PW-1:0]    exp_c;
    bit stable_ok;
    big          = '0;
    big[WIDTH-1] = 1'b1;
    exp_c        = '0;
    exp_c[WIDTH] = 1'b1;
    core_lat = 30;
    set_op(1, big, WIDTH'(2));
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0000;
    wait_rsp(n);
    n_checks++;
    if (n >= 3000 || bus.rsp_c !== exp_c || bus.rsp_id !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_product: got c=%0h id=%0d expected c=%0h id=1", bus.rsp_c, bus.rsp_id, exp_c);
    end
    bus.req_valid = 4'b0100;
    stable_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_c !== exp_c || bus.rsp_id !== 2'd1 ||
          bus.rsp_err !== 1'b0 || bus.req_ready !== 4'b0000 || bus.mul_start !== 1'b0 ||
          dbg_state !== 2'd3)
        stable_ok = 1'b0;
    end
    n_checks++;
    if (stable_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold_stable: got stable=%b expected 1", stable_ok);
    end
    bus.rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (dbg_state !== 2'd0 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_release: got state=%0d busy=%b rv=%b rr=%b expected 0/0/0/0100",
               dbg_state, bus.busy, bus.rsp_valid, bus.req_ready);
    end
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_watchdog();
    int n;
    core_hang = 1'b1;
    set_op(3, WIDTH'(7), WIDTH'(9));
    bus.req_valid = 4'b1000;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL wd_grant: got %b expected 1000", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    wait_rsp(n);
    n_checks++;
    if (n + 1 != MAXLAT + 2) begin
      n_fail++;
      $display("FAIL wd_latency: got %0d expected %0d", n + 1, MAXLAT + 2);
    end
    n_checks++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_c !== '0 || bus.rsp_id !== 2'd3) begin
      n_fail++;
      $display("FAIL wd_rsp: got err=%b c=%0h id=%0d expected 1/0/3", bus.rsp_err, bus.rsp_c, bus.rsp_id);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    core_hang = 1'b0;
    core_lat  = 30;
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = 4'b0000;
    wait_rsp(n);
    n_checks++;
    if (n >= 3000 || bus.rsp_err !== 1'b0 || bus.rsp_c !== PW'(63)) begin
      n_fail++;
      $display("FAIL wd_recover: got err=%b c=%0h wait=%0d expected 0/3f", bus.rsp_err, bus.rsp_c, n);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_spurious_reset();
    int n;
    bit quiet_ok;
    spur_req = 1'b1;
    tick();
    spur_req = 1'b0;
    quiet_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) quiet_ok = 1'b0;
    end
    n_checks++;
    if (quiet_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL spurious_idle_done: got quiet=%b expected 1", quiet_ok);
    end
    core_lat = 572;
    set_op(1, WIDTH'(11), WIDTH'(13));
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0000;
    repeat (100) tick();
    n_checks++;
    if (dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_pre_run: got state=%0d expected 2", dbg_state);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.mul_start, bus.rsp_valid, bus.rsp_err, bus.busy, bus.rsp_id, dbg_state} !== '0 ||
        bus.mul_a !== '0 || bus.mul_b !== '0 || bus.rsp_c !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got st=%b rv=%b busy=%b state=%0d a=%0h expected all 0",
               bus.mul_start, bus.rsp_valid, bus.busy, dbg_state, bus.mul_a);
    end
    tick();
    rst = 1'b0;
    quiet_ok = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) quiet_ok = 1'b0;
    end
    n_checks++;
    if (quiet_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL stale_done_ignored: got quiet=%b expected 1", quiet_ok);
    end
    core_lat = 30;
    set_op(2, WIDTH'(17), WIDTH'(19));
    bus.req_valid = 4'b0100;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL post_reset_grant: got %b expected 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    wait_rsp(n);
    n_checks++;
    if (n >= 3000 || bus.rsp_id !== 2'd2 || bus.rsp_c !== PW'(323) || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_rsp: got id=%0d c=%0h err=%b expected 2/143/0", bus.rsp_id, bus.rsp_c, bus.rsp_err);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_collision();
    int n;
    core_lat = MAXLAT;
    set_op(0, WIDTH'(1000), WIDTH'(1000));
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0000;
    wait_rsp(n);
    n_checks++;
    if (n + 1 != MAXLAT + 2) begin
      n_fail++;
      $display("FAIL coll_latency: got %0d expected %0d", n + 1, MAXLAT + 2);
    end
    n_checks++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_c !== PW'(1000000) || bus.rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL coll_rsp: got err=%b c=%0h id=%0d expected 0/f4240/0", bus.rsp_err, bus.rsp_c, bus.rsp_id);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_spurious_reset();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/booth_mul_sched.md
Name: booth_mul_sched

Overview:
- Round-robin scheduler that shares one sequential Booth multiplier core (WIDTH x WIDTH, multi-cycle, start/done interface) among NREQ requesters.
- Arbitrates requests and latches the operands for the core.
- Pulses the core's start, waits for done with a watchdog, then returns the tagged product on a valid/ready response port.
- Sits between client engines (e.g. ECC point-arithmetic units) and the multiplier core.

Parameters:
- WIDTH, 571, operand width in bits; product is 2*WIDTH.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, tag width = clog2(NREQ).
- MAXLAT, 1023, watchdog limit in RUN cycles; must be greater than the core latency.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  request accepted, one-hot or zero
- req_a  in  NREQ*WIDTH  operand A; requester i occupies slice [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing as req_a
- mul_start  out  1  one-cycle start pulse to the core
- mul_a  out  WIDTH  registered operand A to the core
- mul_b  out  WIDTH  registered operand B to the core
- mul_done  in  1  core result valid, one-cycle pulse
- mul_c  in  2*WIDTH  core product
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_c  out  2*WIDTH  product
- rsp_err  out  1  watchdog timeout; rsp_c is forced to 0 when set
- busy  out  1  state is not IDLE

Behaviour:
- Reset values: state IDLE; req_ready=0; mul_start=0; mul_a=0; mul_b=0; rsp_valid=0; rsp_id=0; rsp_c=0; rsp_err=0; busy=0; rr pointer last=NREQ-1; watchdog counter=0.
- Reset asserted mid-operation aborts immediately. Any in-flight core result is discarded. A mul_done arriving after reset release while in IDLE is ignored.
- States: IDLE, LAUNCH, RUN, HOLD.
- IDLE, arbitration:
  - Grant g = first i with req_valid[i], searching from (last+1) mod NREQ upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On that edge: mul_a <= req_a slice g, mul_b <= req_b slice g, rsp_id <= g, last <= g, go to LAUNCH.
  - No req_valid: stay in IDLE, req_ready=0.
  - req_ready is 0 in every state except IDLE.
- LAUNCH:
  - mul_start=1 for exactly this cycle.
  - Watchdog counter cleared; go to RUN.
  - mul_a and mul_b are held stable until the next grant.
- RUN:
  - Counter increments each cycle.
  - mul_done=1: rsp_c <= mul_c, rsp_err <= 0, rsp_valid <= 1, go to HOLD.
  - Counter reaches MAXLAT without mul_done: rsp_c <= 0, rsp_err <= 1, rsp_valid <= 1, go to HOLD.
  - mul_done and the timeout in the same cycle: mul_done wins.
- HOLD:
  - rsp_valid, rsp_id, rsp_c and rsp_err are held stable while rsp_ready=0.
  - rsp_valid and rsp_ready both high: rsp_valid <= 0, go to IDLE. A new grant is possible on the following cycle, never in the same cycle.
  - mul_done in HOLD or IDLE is ignored. No capture, no error.
- Latency with core latency L (start cycle to done cycle):
  - Request accepted at cycle T.
  - mul_start at T+1.
  - mul_done at T+1+L.
  - rsp_valid first high at T+2+L.
- Throughput: at most one operation in flight; no overlap.
- Fairness: a continuously requesting client is granted within NREQ grants.
- Arithmetic: the scheduler never alters operands or product; widths pass through unchanged. Sign handling belongs to the core.

Test Plan:
- Single request: req_valid=4'b0001, a=3, b=5, core model L=572 returns a*b. Expect req_ready[0] in the same cycle, mul_start 1 cycle later, rsp_valid at T+574, rsp_c=15, rsp_id=0, rsp_err=0.
- Round-robin: req_valid=4'b1111 held, rsp_ready=1. Expect grant order 0,1,2,3,0; each rsp_id matches its grant.
- Backpressure: rsp_ready=0 for 50 cycles after rsp_valid with a=2^570, b=2. Expect rsp_c=2^571 held stable, req_ready=0 throughout, no mul_start, IDLE entered 1 cycle after rsp_ready rises.
- Watchdog: core never asserts mul_done. Expect rsp_valid with rsp_err=1 and rsp_c=0 after MAXLAT RUN cycles. Next request completes normally with rsp_err=0.
- Spurious done and reset: mul_done pulse in IDLE produces no rsp_valid. Reset asserted 100 cycles into RUN gives all outputs 0 asynchronously. After release, a request from requester 2 is granted first with last=NREQ-1.
- Done/timeout collision: mul_done in the same cycle the counter reaches MAXLAT. Expect rsp_err=0 and rsp_c=mul_c.
